// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu memory path: bridge FSM encoding, the default
// transaction timeout and the read value returned when a data read times out.
package cpu_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DREAD  = 2'd2,
        ST_DWRITE = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam logic [63:0] ERR_RDATA = '1;
endpackage

// File: rtl/mem_bridge_if.sv
// Single-ported external memory bus with a req/ack handshake.
interface mem_bridge_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_bridge_ibuf_entry.sv
// One-entry instruction buffer: fill from a completed fetch, hit compare
// against the fetch address, and write-through from completed data writes.
module ibuf_entry #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] lookup_addr,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    input  logic          wt_en,
    input  logic [AW-1:0] wt_addr,
    input  logic [DW-1:0] wt_data,
    output logic          hit,
    output logic [DW-1:0] data
);
    logic          valid;
    logic [AW-1:0] addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            addr  <= fill_addr;
            data  <= fill_data;
        end else if (wt_en && valid && (wt_addr == addr)) begin
            data  <= wt_data;
        end
    end

    assign hit = valid && (addr == lookup_addr);
endmodule

// File: rtl/mem_bridge.sv
// Bridges cpu instruction fetch and data read/write onto one req/ack memory,
// with a one-entry instruction buffer, fixed arbitration and a timeout.
module mem_bridge
    import cpu_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_bus,
    output logic          i_valid,
    input  logic          memory_read,
    input  logic          memory_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          stall,
    output logic          err,
    mem_bridge_if.master  mem
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          start, ack_hit, tmo_hit, data_req;

    ibuf_entry #(.AW(AW), .DW(DW)) u_ibuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (i_addr),
        .fill_en     (ack_hit && (state == ST_IFETCH)),
        .fill_addr   (mem.addr),
        .fill_data   (mem.rdata),
        .wt_en       (ack_hit && (state == ST_DWRITE)),
        .wt_addr     (mem.addr),
        .wt_data     (mem.wdata),
        .hit         (i_valid),
        .data        (i_bus)
    );

    // The core still shows its request during the d_done cycle; that request
    // has just been served and must not start a second access.
    assign data_req = (memory_read | memory_write) && !d_done;
    assign stall    = ((memory_read | memory_write) && !d_done) || !i_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_req && memory_write)     state_nxt = ST_DWRITE;
                else if (data_req && memory_read) state_nxt = ST_DREAD;
                else if (!i_valid)                state_nxt = ST_IFETCH;
            end
            default: begin
                // Ack takes precedence over a timeout landing on the same edge.
                if (mem.ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
        start = (state == ST_IDLE) && (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            d_done <= 1'b0;
            err    <= 1'b0;
            if (start) begin
                mem.req   <= 1'b1;
                mem.we    <= (state_nxt == ST_DWRITE);
                mem.addr  <= (state_nxt == ST_IFETCH) ? i_addr : d_addr;
                mem.wdata <= d_wdata;
                tmo_cnt   <= '0;
            end else if (ack_hit || tmo_hit) begin
                mem.req <= 1'b0;
                mem.we  <= 1'b0;
                err     <= tmo_hit;
                if (state != ST_IFETCH) d_done <= 1'b1;
                if (state == ST_DREAD)
                    d_rdata <= ack_hit ? mem.rdata : ERR_RDATA[DW-1:0];
            end else if (mem.req) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: a behavioural memory with programmable ack
// latency, expected data results queued at issue and checked on d_done.
module tb_mem_bridge;
    typedef struct packed {
        logic        is_rd;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_addr, i_bus, d_addr, d_wdata, d_rdata;
    logic        i_valid, memory_read, memory_write, d_done, stall, err;

    logic        resp_ack = 1'b0, stray_ack = 1'b0, ack_en, req_q = 1'b0;
    logic [15:0] resp_rdata = '0;
    int          ack_lat, req_cycles = 0, req_starts = 0;
    int          n_checks = 0, n_pass = 0;
    logic [15:0] model [0:255];
    exp_t        sb [$];

    mem_bridge_if #(.AW(16), .DW(16)) mem ();
    assign mem.ack   = resp_ack | stray_ack;
    assign mem.rdata = resp_rdata;

    mem_bridge #(.AW(16), .DW(16), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_addr       (i_addr),
        .i_bus        (i_bus),
        .i_valid      (i_valid),
        .memory_read  (memory_read),
        .memory_write (memory_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .stall        (stall),
        .err          (err),
        .mem          (mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Memory model: ack in the ack_lat-th cycle of mem_req when enabled.
    always @(negedge clk) begin
        if (mem.req) begin
            req_cycles++;
            resp_ack = ack_en && (req_cycles == ack_lat);
            if (resp_ack) begin
                resp_rdata = model[mem.addr[7:0]];
                if (mem.we) model[mem.addr[7:0]] = mem.wdata;
            end
        end else begin
            req_cycles = 0;
            resp_ack   = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mem.req && !req_q) req_starts++;
        req_q = mem.req;
        if (d_done) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_rd) chk("d_rdata", 32'(d_rdata), 32'(e.rdata));
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic wait_ivalid(input string tag, output int cycles);
        logic seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (i_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic data_access(input logic wr, input logic rd, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_rd,
                               input logic exp_err, input int exp_req);
        logic got = 1'b0;
        int   reqc = 0;
        sb.push_back('{is_rd: rd && !wr, err: exp_err, rdata: exp_rd});
        d_addr = addr; d_wdata = wdata; memory_write = wr; memory_read = rd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("req_start", 32'(mem.req), 32'd1);
                chk("mem_addr", 32'(mem.addr), 32'(addr));
                chk("mem_we", 32'(mem.we), 32'(wr));
                if (wr) chk("mem_wdata", 32'(mem.wdata), 32'(wdata));
            end
            if (mem.req) reqc++;
            if (d_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("req_cycles", 32'(reqc), 32'(exp_req));
        memory_write = 1'b0; memory_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, s;
        logic ok;
        rst_n = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
        memory_read = 1'b0; memory_write = 1'b0; ack_en = 1'b1; ack_lat = 3;
        for (int i = 0; i < 256; i++) model[i] = 16'h1000 + 16'(i);
        model[0] = 16'h1234; model[8'h40] = 16'hBEEF;
        repeat (2) @(negedge clk);

        chk("rst_req", 32'(mem.req), 32'd0);
        chk("rst_we", 32'(mem.we), 32'd0);
        chk("rst_addr", 32'(mem.addr), 32'd0);
        chk("rst_done", 32'(d_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(d_rdata), 32'd0);
        chk("rst_ivalid", 32'(i_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);

        // Cold miss at 0x0000, memory acks in the third request cycle.
        rst_n = 1'b1;
        @(negedge clk);
        chk("fetch_req", 32'(mem.req), 32'd1);
        chk("fetch_addr", 32'(mem.addr), 32'h0000);
        chk("fetch_we", 32'(mem.we), 32'd0);
        chk("fetch_stall", 32'(stall), 32'd1);
        wait_ivalid("fill0", cyc);
        chk("fill0_latency", 32'(cyc), 32'd3);
        chk("fill0_ibus", 32'(i_bus), 32'h1234);
        chk("fill0_starts", 32'(req_starts), 32'd1);

        // Buffer hit holds with no memory traffic.
        s = req_starts; ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!i_valid || mem.req) ok = 1'b0;
        end
        chk("hit_hold", 32'(ok), 32'd1);
        chk("hit_stall", 32'(stall), 32'd0);
        chk("hit_starts", 32'(req_starts), 32'(s));

        // Data read beats a pending instruction miss; fetch follows.
        ack_lat = 1;
        i_addr = 16'h0010;
        data_access(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 1);
        wait_ivalid("fill10", cyc);
        chk("fill10_ibus", 32'(i_bus), 32'h1010);
        chk("fill10_starts", 32'(req_starts), 32'(s + 2));

        // Write-through to the buffered address.
        ack_lat = 2;
        i_addr = 16'h0000;
        wait_ivalid("fill0b", cyc);
        chk("fill0b_ibus", 32'(i_bus), 32'h1234);
        s = req_starts;
        data_access(1'b1, 1'b0, 16'h0000, 16'h5555, 16'h0000, 1'b0, 2);
        chk("wt_ibus", 32'(i_bus), 32'h5555);
        chk("wt_ivalid", 32'(i_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("wt_no_refetch", 32'(req_starts), 32'(s + 1));
        chk("wt_mem", 32'(model[0]), 32'h5555);

        // Read and write together: write only, one d_done.
        data_access(1'b1, 1'b1, 16'h0020, 16'hA5A5, 16'h0000, 1'b0, 2);
        repeat (3) @(negedge clk);
        chk("both_mem", 32'(model[8'h20]), 32'hA5A5);

        // Read timeout, then ack on the timeout edge.
        ack_en = 1'b0;
        data_access(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hFFFF, 1'b1, 4);
        @(negedge clk);
        ack_en = 1'b1; ack_lat = 4;
        data_access(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 4);
        @(negedge clk);

        // Reset in the middle of a write; a late ack lands on the release edge.
        ack_en = 1'b0;
        d_addr = 16'h0030; d_wdata = 16'h7777; memory_write = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_wr_req", 32'(mem.req), 32'd1);
        rst_n = 1'b0; memory_write = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", 32'(mem.req), 32'd0);
        chk("mid_rst_ivalid", 32'(i_valid), 32'd0);
        ack_en = 1'b1; ack_lat = 2;
        rst_n = 1'b1; stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        chk("post_rst_req", 32'(mem.req), 32'd1);
        chk("post_rst_we", 32'(mem.we), 32'd0);
        chk("post_rst_addr", 32'(mem.addr), 32'h0000);
        chk("stray_ignored", 32'(i_valid), 32'd0);
        wait_ivalid("refill", cyc);
        chk("refill_ibus", 32'(i_bus), 32'h5555);
        chk("aborted_wr", 32'(model[8'h30]), 32'h1030);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the cpu memory interface: turns its separate instruction-fetch and data read/write requests into transactions on one single-ported external memory with a req/ack handshake.
- Holds a one-entry instruction buffer, arbitrates fetch against data accesses, and bounds each transaction with a timeout.
- Drives a stall output so the core can be held while the memory is busy.
- Tristate handling of d_bus stays in the top level; this block uses split write and read data.

Parameters:
- AW, 16, address width of the CPU side and the memory side.
- DW, 16, data width.
- TIMEOUT, 255, maximum cycles mem_req stays high without mem_ack before the transaction is aborted.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_addr  in  AW  instruction fetch address from the program counter.
- i_bus  out  DW  instruction word (buffer contents).
- i_valid  out  1  i_bus holds the word at i_addr.
- memory_read  in  1  data read request (level, held until d_done).
- memory_write  in  1  data write request (level, held until d_done).
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read data; valid when d_done is high.
- d_done  out  1  one-cycle pulse: data access complete.
- stall  out  1  core must hold its state this cycle.
- err  out  1  one-cycle pulse on timeout.
- mem_req, mem_we  out  1  memory request and write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion strobe (one cycle).

Behaviour:
- Reset (rst_n low at an edge, including mid-transaction):
  - state goes to IDLE; buf_valid=0; buf_addr=0; buf_data=0; timeout counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata, d_rdata, d_done and err are all 0.
  - An outstanding memory transaction is abandoned.
  - A stray mem_ack that arrives in IDLE is ignored.
- Combinational outputs:
  - i_valid = buf_valid && (buf_addr == i_addr); i_bus = buf_data.
  - stall = (memory_read|memory_write) && !d_done, OR !i_valid.
- FSM states: IDLE, IFETCH, DREAD, DWRITE.
- IDLE priority order, sampled at the edge:
  1. memory_write → DWRITE.
  2. memory_read → DREAD.
  3. !i_valid → IFETCH.
  4. Otherwise stay in IDLE.
  - If memory_write and memory_read are both high, the write wins. The read is not performed and d_done fires once.
- On entering any non-IDLE state, register mem_req=1, mem_addr (d_addr or i_addr) and mem_we=1 for DWRITE only. mem_wdata=d_wdata. These outputs hold stable until the transaction ends.
- In each non-IDLE state, mem_ack sampled high at an edge does the following:
  - mem_req→0 and mem_we→0; return to IDLE.
  - DREAD: d_rdata←mem_rdata; d_done=1 for one cycle.
  - DWRITE: d_done=1 for one cycle. If d_addr==buf_addr and buf_valid, buf_data←d_wdata (write-through coherence).
  - IFETCH: buf_addr←mem_addr; buf_data←mem_rdata; buf_valid←1.
- Latency:
  - Request visible at edge 0; mem_req high after edge 0.
  - mem_ack sampled at edge k (k≥1); d_done high, or i_valid updated, after edge k.
  - A zero-wait memory (ack in the first cycle of mem_req) gives 2-cycle data access.
  - Minimum gap between transactions: 1 IDLE cycle.
- Timeout:
  - The counter clears on entering a non-IDLE state and increments each cycle mem_req is high.
  - When it reaches TIMEOUT with no ack: mem_req→0, err=1 for one cycle, return to IDLE.
  - DREAD: d_rdata=all-ones, d_done pulses.
  - DWRITE: d_done pulses and the buffer is not updated.
  - IFETCH: buffer unchanged, so the fetch retries.
  - If the ack arrives on the same edge as the timeout, the ack wins and err stays 0.
- An i_addr change during IFETCH does not abort the fetch. The fetched word is buffered, and a fresh miss refetches afterwards.
- Request inputs dropped before d_done: the transaction still completes and the d_done pulse is ignored by the core.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state encoding constants ST_IDLE=2'd0, ST_IFETCH=2'd1, ST_DREAD=2'd2, ST_DWRITE=2'd3;
  - DEFAULT_TIMEOUT;
  - the all-ones error read value.
- One natural sub-module, ibuf_entry: the instruction buffer register, its hit compare, and its write-through update port.
- The FSM and timeout counter stay in mem_bridge.

Test Plan:
- Reset then i_addr=0x0000; memory acks after 3 cycles with 0x1234 → one IFETCH, i_valid rises after the ack edge with i_bus=0x1234; stall high until then.
- Buffer hit: i_addr held at 0x0000 for 10 cycles after the fill → no further mem_req, i_valid=1 throughout.
- memory_read with d_addr=0x0040 while an instruction miss is pending → DREAD issued first: mem_addr=0x0040, mem_we=0. Ack with 0xBEEF → d_done pulse with d_rdata=0xBEEF, then IFETCH follows.
- memory_write with d_addr=0x0000 and d_wdata=0x5555 while the buffer holds 0x0000 → mem_we=1, mem_wdata=0x5555. After the ack, i_bus=0x5555 and i_valid stays 1 with no refetch.
- DREAD with no ack for TIMEOUT=4 → mem_req drops after 4 cycles; err and d_done pulse together; d_rdata=0xFFFF. A repeat with the ack on cycle 4 gives err=0 and the ack data returned.
- rst_n low mid-DWRITE, with a late mem_ack arriving after release → mem_req=0 and buf_valid=0 immediately; the late ack is ignored; the next miss starts a fresh IFETCH.
